mode_sequencer: RTL and testbench

//  Top-level mode FSM for the lab-4 display. Generates the 3-bit display-mode flag

---
 rtl/mode_sequencer_pkg.sv | 19 +
 rtl/mode_sequencer_hold_timer.sv | 36 +++
 rtl/mode_sequencer.sv | 105 ++++++++++
 tb/tb_mode_sequencer.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/mode_sequencer_pkg.sv
// Display-mode codes shared by the mode sequencer and the output multiplexer.
// The flag driven to the multiplexer is the FSM state encoding itself.
package mode_sequencer_pkg;

    localparam logic [2:0] MODE_ACTIVATE  = 3'd0;
    localparam logic [2:0] MODE_COUNTDOWN = 3'd1;
    localparam logic [2:0] MODE_LOA       = 3'd2;
    localparam logic [2:0] MODE_QUAR      = 3'd3;
    localparam logic [2:0] MODE_DONE      = 3'd4;

    typedef enum logic [2:0] {
        ST_ACTIVATE  = MODE_ACTIVATE,
        ST_COUNTDOWN = MODE_COUNTDOWN,
        ST_LOA       = MODE_LOA,
        ST_QUAR      = MODE_QUAR,
        ST_DONE      = MODE_DONE
    } mode_e;

endpackage

// File: rtl/mode_sequencer_hold_timer.sv
// Tick counter with sync clear and terminal-count flag; shared by the LOA and DONE holds.
// Registered count, combinational terminal count; no backpressure.
module mode_sequencer_hold_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] last_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] hold_q;
    logic [CNT_W-1:0] hold_d;

    always_comb begin
        hold_d = hold_q;
        if (clr_i) begin
            hold_d = '0;
        end else if (en_i) begin
            hold_d = hold_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    assign tc_o = (hold_q == last_i);

endmodule

// File: rtl/mode_sequencer.sv
// Display-mode FSM owning the countdown, failed-attempt and hold counters.
// All outputs registered, 1-cycle latency from qualifying input; no backpressure.
module mode_sequencer
    import mode_sequencer_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int COUNT_INIT = 15,
    parameter int MAX_FAILS  = 3,
    parameter int LOA_TICKS  = 5,
    parameter int DONE_TICKS = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             start,
    input  logic             pass_ok,
    input  logic             pass_fail,
    input  logic             clear,
    output logic [2:0]       flag,
    output logic [CNT_W-1:0] count,
    output logic [2:0]       fails,
    output logic             mode_entry
);

    localparam logic [CNT_W-1:0] COUNT_RELOAD = CNT_W'(COUNT_INIT);
    localparam logic [CNT_W-1:0] LOA_LAST     = CNT_W'(LOA_TICKS - 1);
    localparam logic [CNT_W-1:0] DONE_LAST    = CNT_W'(DONE_TICKS - 1);
    localparam logic [2:0]       FAIL_LIMIT   = 3'(MAX_FAILS);

    mode_e            state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [2:0]       fails_q, fails_d;
    logic             mode_entry_q, mode_entry_d;
    logic             hold_tc;
    logic             holding;

    assign holding = (state_q == ST_LOA) || (state_q == ST_DONE);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        fails_d = fails_q;
        case (state_q)
            ST_ACTIVATE: begin
                if (start) state_d = ST_COUNTDOWN;
            end
            ST_COUNTDOWN: begin
                if (pass_ok) begin
                    state_d = ST_DONE;
                end else if (pass_fail) begin
                    fails_d = fails_q + 3'd1;
                    if (fails_d == FAIL_LIMIT) state_d = ST_QUAR;
                end else if (tick && (count_q != '0)) begin
                    count_d = count_q - CNT_W'(1);
                    if (count_q == CNT_W'(1)) state_d = ST_LOA;
                end
            end
            ST_LOA, ST_DONE: begin
                if (tick && hold_tc) state_d = ST_ACTIVATE;
            end
            ST_QUAR: begin
                if (clear) state_d = ST_ACTIVATE;
            end
            default: state_d = ST_ACTIVATE;
        endcase
        // Reload on the same edge that enters ACTIVATE so the first visible cycle is clean.
        if (state_d == ST_ACTIVATE) begin
            count_d = COUNT_RELOAD;
            fails_d = '0;
        end
        mode_entry_d = (state_d != state_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_ACTIVATE;
            count_q      <= COUNT_RELOAD;
            fails_q      <= '0;
            mode_entry_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            fails_q      <= fails_d;
            mode_entry_q <= mode_entry_d;
        end
    end

    // Cleared on every mode change, so each LOA/DONE visit starts counting from zero.
    mode_sequencer_hold_timer #(
        .CNT_W (CNT_W)
    ) u_hold_timer (
        .clk    (clk),
        .rst    (rst),
        .clr_i  ((state_d != state_q) || !holding),
        .en_i   (tick),
        .last_i ((state_q == ST_DONE) ? DONE_LAST : LOA_LAST),
        .tc_o   (hold_tc)
    );

    assign flag       = state_q;
    assign count      = count_q;
    assign fails      = fails_q;
    assign mode_entry = mode_entry_q;

endmodule

// File: tb/tb_mode_sequencer.sv
// Directed checks of mode_sequencer with default parameters (15/3/5/5).
module tb_mode_sequencer;

    logic       clk = 1'b0;
    logic       rst, tick, start, pass_ok, pass_fail, clear;
    logic [2:0] flag;
    logic [7:0] count;
    logic [2:0] fails;
    logic       mode_entry;
    int         checks = 0;
    int         errors = 0;

    mode_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .start      (start),
        .pass_ok    (pass_ok),
        .pass_fail  (pass_fail),
        .clear      (clear),
        .flag       (flag),
        .count      (count),
        .fails      (fails),
        .mode_entry (mode_entry)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic t, input logic s,
                        input logic ok, input logic f, input logic c);
        rst = r; tick = t; start = s; pass_ok = ok; pass_fail = f; clear = c;
        @(posedge clk);
        #1;
        rst = 1'b0; tick = 1'b0; start = 1'b0; pass_ok = 1'b0; pass_fail = 1'b0; clear = 1'b0;
    endtask

    task automatic idle();    step(0, 0, 0, 0, 0, 0); endtask
    task automatic do_tick(); step(0, 1, 0, 0, 0, 0); endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] f, input logic [7:0] c,
                           input logic [2:0] fl, input logic me);
        chk({tag, ".flag"}, 32'(flag), 32'(f));
        chk({tag, ".count"}, 32'(count), 32'(c));
        chk({tag, ".fails"}, 32'(fails), 32'(fl));
        chk({tag, ".entry"}, 32'(mode_entry), 32'(me));
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; start = 1'b0; pass_ok = 1'b0; pass_fail = 1'b0; clear = 1'b0;
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk_all("reset", 3'd0, 8'd15, 3'd0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            idle();
            chk_all("idle", 3'd0, 8'd15, 3'd0, 1'b0);
        end

        // Full countdown to LOA, then hold back to ACTIVATE
        step(0, 0, 1, 0, 0, 0);
        chk_all("start", 3'd1, 8'd15, 3'd0, 1'b1);
        idle();
        chk_all("cd_idle", 3'd1, 8'd15, 3'd0, 1'b0);
        for (int i = 1; i < 15; i++) begin
            do_tick();
            chk_all("cd_tick", 3'd1, 8'(15 - i), 3'd0, 1'b0);
        end
        do_tick();
        chk_all("loa_entry", 3'd2, 8'd0, 3'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            do_tick();
            chk_all("loa_hold", 3'd2, 8'd0, 3'd0, 1'b0);
        end
        do_tick();
        chk_all("loa_exit", 3'd0, 8'd15, 3'd0, 1'b1);

        // pass_ok after 3 ticks -> DONE with frozen count
        step(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) do_tick();
        chk_all("cd_12", 3'd1, 8'd12, 3'd0, 1'b0);
        step(0, 0, 0, 1, 0, 0);
        chk_all("done_entry", 3'd4, 8'd12, 3'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            do_tick();
            chk_all("done_hold", 3'd4, 8'd12, 3'd0, 1'b0);
        end
        do_tick();
        chk_all("done_exit", 3'd0, 8'd15, 3'd0, 1'b1);

        // Three failures -> QUAR; only clear releases
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        chk_all("fail1", 3'd1, 8'd15, 3'd1, 1'b0);
        step(0, 0, 0, 0, 1, 0);
        chk_all("fail2", 3'd1, 8'd15, 3'd2, 1'b0);
        step(0, 0, 0, 0, 1, 0);
        chk_all("quar_entry", 3'd3, 8'd15, 3'd3, 1'b1);
        do_tick();
        chk_all("quar_tick", 3'd3, 8'd15, 3'd3, 1'b0);
        step(0, 0, 1, 0, 0, 0);
        chk_all("quar_start", 3'd3, 8'd15, 3'd3, 1'b0);
        step(0, 0, 0, 1, 0, 0);
        chk_all("quar_passok", 3'd3, 8'd15, 3'd3, 1'b0);
        step(0, 0, 0, 0, 0, 1);
        chk_all("quar_clear", 3'd0, 8'd15, 3'd0, 1'b1);

        // Priority at count==1: pass_ok over tick, then pass_fail over tick
        step(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 14; i++) do_tick();
        chk_all("cd_1", 3'd1, 8'd1, 3'd0, 1'b0);
        step(0, 1, 0, 1, 0, 0);
        chk_all("ok_vs_tick", 3'd4, 8'd1, 3'd0, 1'b1);
        for (int i = 0; i < 5; i++) do_tick();
        chk_all("done_exit2", 3'd0, 8'd15, 3'd0, 1'b1);
        step(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 14; i++) do_tick();
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        chk_all("cd_1_f2", 3'd1, 8'd1, 3'd2, 1'b0);
        step(0, 1, 0, 0, 1, 0);
        chk_all("fail_vs_tick", 3'd3, 8'd1, 3'd3, 1'b1);
        step(0, 0, 0, 0, 0, 1);
        chk_all("quar_clear2", 3'd0, 8'd15, 3'd0, 1'b1);

        // Reset in COUNTDOWN, in LOA, and coinciding with start
        step(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) do_tick();
        step(0, 0, 0, 0, 1, 0);
        chk_all("cd_7", 3'd1, 8'd7, 3'd1, 1'b0);
        step(1, 1, 0, 1, 0, 0);
        chk_all("rst_cd", 3'd0, 8'd15, 3'd0, 1'b0);
        step(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 17; i++) do_tick();
        chk_all("loa_mid", 3'd2, 8'd0, 3'd0, 1'b0);
        step(1, 1, 0, 0, 0, 0);
        chk_all("rst_loa", 3'd0, 8'd15, 3'd0, 1'b0);
        step(1, 0, 1, 0, 0, 0);
        chk_all("rst_start", 3'd0, 8'd15, 3'd0, 1'b0);

        // Hold counter restarts from zero after a reset in LOA
        step(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 15; i++) do_tick();
        for (int i = 0; i < 4; i++) do_tick();
        chk_all("loa_hold2", 3'd2, 8'd0, 3'd0, 1'b0);
        do_tick();
        chk_all("loa_exit2", 3'd0, 8'd15, 3'd0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
